// File: rtl/field_mult_pkg.sv
// Shared definitions for the digit-serial GF(2^WIDTH) multiplier family:
// default reduction polynomial, FSM state encoding and the alpha-multiply helper.
package field_mult_pkg;

    // x^32 + x^7 + x^3 + x^2 + 1 with the x^32 term left implicit.
    localparam logic [31:0] DEFAULT_POLY = 32'h0000_008D;

    // Widest field the helper function can serve.
    localparam int MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Multiply v by alpha in GF(2^width). Bits at and above 'width' are
    // don't-care; callers truncate the result back to their field width.
    function automatic logic [MAX_WIDTH-1:0] mul_alpha(
        input logic [MAX_WIDTH-1:0] v,
        input int                   width,
        input logic [MAX_WIDTH-1:0] poly
    );
        logic [MAX_WIDTH-1:0] r;
        r = v << 1;
        if (v[width-1]) begin
            r = r ^ poly;
        end
        return r;
    endfunction

endpackage

// File: rtl/field_mult_ds_step.sv
// Combinational Horner step: folds one DIGIT-bit slice of b (MSB first)
// into the accumulator, i.e. acc_next = acc*alpha^DIGIT + a*digit mod poly.
module field_mult_ds_step
    import field_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [DIGIT-1:0] b_digit,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] t;

    // NOTE: blocking assignments are intentional here; each loop pass feeds the
    // next within one combinational evaluation, and t is defaulted first so no
    // latch is inferred.
    always_comb begin
        t = acc;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            t = WIDTH'(mul_alpha(MAX_WIDTH'(t), WIDTH, MAX_WIDTH'(poly)));
            if (b_digit[i]) begin
                t = t ^ a;
            end
        end
        acc_next = t;
    end

endmodule

// File: rtl/field_mult_ds.sv
// Digit-serial GF(2^WIDTH) multiplier with valid/ready on both sides.
// Define FIELD_MULT_DS_MAC_EN to add in_c and produce a*b + c.
module field_mult_ds
    import field_mult_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               DIGIT = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef FIELD_MULT_DS_MAC_EN
    input  logic [WIDTH-1:0] in_c,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("field_mult_ds: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;

    // b_reg shifts left each RUN cycle, so the next digit is always on top.
    field_mult_ds_step #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_step (
        .acc      (acc),
        .a        (a_reg),
        .b_digit  (b_reg[WIDTH-1 -: DIGIT]),
        .poly     (POLY),
        .acc_next (acc_next)
    );

`ifdef FIELD_MULT_DS_MAC_EN
    logic [WIDTH-1:0] c_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg <= '0;
        end else if (!clr && state == IDLE && in_valid && in_ready) begin
            c_reg <= in_c;
        end
    end

    assign result = acc ^ c_reg;
`else
    assign result = acc;
`endif

    // NOTE: operand registers are reset along with control state so the block
    // leaves reset fully deterministic; they are flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else if (clr) begin
            // Abort wins over every handshake; out_data keeps its last value.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(N)) begin
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= acc_next;
                        b_reg <= b_reg << DIGIT;
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
